seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed scan controller that drives the 4-digit 7-segment decoder.
//  - Holds a 16-bit display value (4 hex nibbles) and 4 dot flags.
//  - Steps a digit index 0..3 at a prescaled rate.
//  - Presents the nibble, dot and blank for that digit together with the 2-bit digit select.
//  - New values load through a strobe and are applied only at frame boundaries, so a frame never shows mixed old/new digits.
// PARAMETERS
//  CLK_DIV  50000  clocks per digit slot (1 kHz slot rate at 50 MHz); legal range >= 2
//  LZB_EN   1      1 = leading-zero blanking enabled, 0 = all digits always shown
// PORTS
//  CLK             in   1   system clock, rising edge
//  RESET_N         in   1   asynchronous, active-low reset
//  LOAD_IN         in   1   one-cycle strobe: capture VALUE_IN/DOTS_IN
//  VALUE_IN        in   16  display value; [3:0]=digit0 (rightmost) .. [15:12]=digit3
//  DOTS_IN         in   4   dot enable per digit, bit n = digit n
//  SEG_SELECT_OUT  out  2   current digit index 0..3
//  BIN_OUT         out  4   nibble for current digit
//  DOT_OUT         out  1   dot flag for current digit (active-high)
//  BLANK_OUT       out  1   1 = current digit is suppressed; integrator gates its anode
//  BUSY_OUT        out  1   1 = a captured load is pending the next frame boundary
//  FRAME_OUT       out  1   one-cycle pulse when a pending load is applied
// BEHAVIOUR
//  Reset (async, RESET_N=0):
//   - prescaler=0, digit=0, shadow value/dots=0, pending=0.
//   - All outputs go to 0 immediately; this applies mid-scan as well.
//  Prescaler:
//   - Counts 0..CLK_DIV-1 and wraps to 0.
//   - tick = (count==CLK_DIV-1).
//   - First tick occurs CLK_DIV cycles after reset release.
//  Digit counter:
//   - Advances on tick only: 0->1->2->3->0.
//   - Each digit is held exactly CLK_DIV cycles.
//   - A frame boundary is a tick while digit==3.
//  Outputs:
//   - SEG_SELECT_OUT, BIN_OUT, DOT_OUT and BLANK_OUT are all registered.
//   - They change on the same edge as the digit index and always describe that index (no skew).
//   - BIN_OUT = shadow[4*d+3:4*d]; DOT_OUT = shadow_dots[d].
//  Load handshake:
//   - LOAD_IN=1 captures VALUE_IN/DOTS_IN into the pending register.
//   - BUSY_OUT=1 from the next cycle.
//   - A further LOAD_IN while pending overwrites the pending value; last load wins.
//   - At a frame boundary with pending set: shadow<=pending, pending cleared, BUSY_OUT->0 and FRAME_OUT=1 for one cycle, all on the same edge.
//   - Digit 0 of the new frame shows the new value.
//   - LOAD_IN on the boundary-tick cycle: VALUE_IN/DOTS_IN go straight to shadow and any older pending value is discarded.
//     On that cycle BUSY_OUT stays 0 and FRAME_OUT pulses.
//   - LOAD_IN is ignored while RESET_N=0.
//  Leading-zero blanking (LZB_EN=1), evaluated on the shadow value:
//   - Digit n (n=3,2,1) is blanked iff all nibbles n..3 are 0 and shadow_dots[n]=0.
//   - Digit 0 is never blanked.
//   - With LZB_EN=0, BLANK_OUT is constant 0.
//  No other state; the shadow value persists indefinitely without loads.
// TESTING (CLK_DIV=4 unless stated)
//  1 Reset: release RESET_N, load 0x1234 -> SEG_SELECT_OUT 0,1,2,3,0 each held 4 clk; BIN_OUT 4,3,2,1.
//    Pull RESET_N low mid-digit-2 -> all outputs 0 same cycle.
//  2 Deferred load: shadow 0x1234; LOAD 0xABCD while digit=1 -> BUSY_OUT=1.
//    BIN_OUT shows 3,2,1 for digits 1..3, then FRAME_OUT pulses and BUSY_OUT=0; digit0 shows 0xD.
//  3 Overwrite: LOAD 0x1111 then LOAD 0x2222 before the boundary -> next frame shows 2,2,2,2; never 1.
//    LOAD 0x5678 on the boundary-tick cycle -> BUSY_OUT stays 0; next digit0 shows 8.
//  4 Blanking: 0x0050 -> BLANK_OUT 0,0,1,1 for digits 0..3.
//    0x0000 -> BLANK_OUT 0,1,1,1.
//    0x0005 with DOTS_IN=4'b0100 -> BLANK_OUT 0,1,0,1, with DOT_OUT=1 on digit2 only.
//  5 LZB_EN=0, value 0x0000 -> BLANK_OUT always 0, BIN_OUT 0 on all digits.
//  6 CLK_DIV=2 stress: random loads every 1..10 clk for 10k cycles.
//    Scoreboard checks each frame matches a single loaded value and that BUSY_OUT/FRAME_OUT obey the rules above.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Load and scan-output bundle between a host/bench and the 4-digit
// 7-segment scan driver.
interface seg7_scan_driver_if;
   logic        LOAD_IN;
   logic [15:0] VALUE_IN;
   logic [3:0]  DOTS_IN;
   logic [1:0]  SEG_SELECT_OUT;
   logic [3:0]  BIN_OUT;
   logic        DOT_OUT;
   logic        BLANK_OUT;
   logic        BUSY_OUT;
   logic        FRAME_OUT;

   modport master (
      output LOAD_IN, VALUE_IN, DOTS_IN,
      input  SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, BUSY_OUT, FRAME_OUT
   );

   modport slave (
      input  LOAD_IN, VALUE_IN, DOTS_IN,
      output SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, BUSY_OUT, FRAME_OUT
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit scan controller: prescaled digit stepping, shadow
// value applied only at frame boundaries, optional leading-zero blanking.
module seg7_scan_driver #(
   parameter int CLK_DIV = 50000,
   parameter bit LZB_EN  = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   seg7_scan_driver_if.slave bus
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       digit_q, digit_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [3:0]       sdots_q, sdots_d;
   logic             pend_q, pend_d;
   logic [15:0]      pend_val_q, pend_val_d;
   logic [3:0]       pend_dots_q, pend_dots_d;
   logic [1:0]       seg_q, seg_d;
   logic [3:0]       bin_q, bin_d;
   logic             dot_q, dot_d;
   logic             blank_q, blank_d;
   logic             frame_q, frame_d;

   logic             tick;
   logic             boundary;
   logic [3:1]       upper_zero;
   logic [3:0]       blank_vec;

   always_comb begin
      tick        = (cnt_q == CNT_LAST);
      boundary    = tick && (digit_q == 2'd3);
      cnt_d       = tick ? '0 : cnt_q + 1'b1;
      digit_d     = tick ? digit_q + 2'd1 : digit_q;
      shadow_d    = shadow_q;
      sdots_d     = sdots_q;
      pend_d      = pend_q;
      pend_val_d  = pend_val_q;
      pend_dots_d = pend_dots_q;
      frame_d     = 1'b0;

      // A load on the boundary cycle bypasses the pending slot entirely.
      if (boundary) begin
         if (bus.LOAD_IN) begin
            shadow_d = bus.VALUE_IN;
            sdots_d  = bus.DOTS_IN;
            pend_d   = 1'b0;
            frame_d  = 1'b1;
         end else if (pend_q) begin
            shadow_d = pend_val_q;
            sdots_d  = pend_dots_q;
            pend_d   = 1'b0;
            frame_d  = 1'b1;
         end
      end else if (bus.LOAD_IN) begin
         pend_d      = 1'b1;
         pend_val_d  = bus.VALUE_IN;
         pend_dots_d = bus.DOTS_IN;
      end
   end

   // Blanking is derived from the next shadow so it lines up with the digit it describes.
   assign upper_zero[3] = (shadow_d[15:12] == 4'h0);
   assign blank_vec[0]  = 1'b0;

   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_blank
         if (gi < 3) begin : g_chain
            assign upper_zero[gi] = (shadow_d[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
         end
         assign blank_vec[gi] = LZB_EN && upper_zero[gi] && !sdots_d[gi];
      end
   endgenerate

   always_comb begin
      seg_d   = digit_d;
      bin_d   = shadow_d[{digit_d, 2'b00} +: 4];
      dot_d   = sdots_d[digit_d];
      blank_d = blank_vec[digit_d];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q       <= '0;
         digit_q     <= 2'd0;
         shadow_q    <= 16'h0000;
         sdots_q     <= 4'h0;
         pend_q      <= 1'b0;
         pend_val_q  <= 16'h0000;
         pend_dots_q <= 4'h0;
         seg_q       <= 2'd0;
         bin_q       <= 4'h0;
         dot_q       <= 1'b0;
         blank_q     <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         digit_q     <= digit_d;
         shadow_q    <= shadow_d;
         sdots_q     <= sdots_d;
         pend_q      <= pend_d;
         pend_val_q  <= pend_val_d;
         pend_dots_q <= pend_dots_d;
         seg_q       <= seg_d;
         bin_q       <= bin_d;
         dot_q       <= dot_d;
         blank_q     <= blank_d;
         frame_q     <= frame_d;
      end
   end

   assign bus.SEG_SELECT_OUT = seg_q;
   assign bus.BIN_OUT        = bin_q;
   assign bus.DOT_OUT        = dot_q;
   assign bus.BLANK_OUT      = blank_q;
   assign bus.BUSY_OUT       = pend_q;
   assign bus.FRAME_OUT      = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and randomised checks of seg7_scan_driver: reset, deferred and
// overwritten loads, leading-zero blanking, no-blanking build, CLK_DIV=2 stress.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   k = 0;

   always #5 clk = ~clk;

   seg7_scan_driver_if bus_a();
   seg7_scan_driver_if bus_b();
   seg7_scan_driver_if bus_c();

   seg7_scan_driver #(.CLK_DIV(4), .LZB_EN(1'b1)) dut_a (.CLK(clk), .RESET_N(rst_n), .bus(bus_a));
   seg7_scan_driver #(.CLK_DIV(4), .LZB_EN(1'b0)) dut_b (.CLK(clk), .RESET_N(rst_n), .bus(bus_b));
   seg7_scan_driver #(.CLK_DIV(2), .LZB_EN(1'b1)) dut_c (.CLK(clk), .RESET_N(rst_n), .bus(bus_c));

   function automatic logic [3:0] nib(input logic [15:0] v, input int d);
      return v[4*d +: 4];
   endfunction

   // k counts rising edges since reset release; outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
      k++;
   endtask

   task automatic run_to(input int n);
      while (k < n) step();
   endtask

   task automatic idle_inputs();
      bus_a.LOAD_IN = 1'b0; bus_a.VALUE_IN = 16'h0; bus_a.DOTS_IN = 4'h0;
      bus_b.LOAD_IN = 1'b0; bus_b.VALUE_IN = 16'h0; bus_b.DOTS_IN = 4'h0;
      bus_c.LOAD_IN = 1'b0; bus_c.VALUE_IN = 16'h0; bus_c.DOTS_IN = 4'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = 0;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      logic [9:0]  outs;
      int          d;
      v = 16'h1234;
      rst_n = 1'b0;
      idle_inputs();
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = 16'hFFFF;
      repeat (2) @(negedge clk);
      outs = {bus_a.SEG_SELECT_OUT, bus_a.BIN_OUT, bus_a.DOT_OUT, bus_a.BLANK_OUT,
              bus_a.BUSY_OUT, bus_a.FRAME_OUT};
      tests++;
      if (outs !== 10'h0) begin
         fails++; $display("FAIL reset_outputs: got %0h, expected 0", outs);
      end
      bus_a.LOAD_IN = 1'b0;
      rst_n = 1'b1;
      k = 0;
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = v;
      step();
      bus_a.LOAD_IN = 1'b0;
      tests++;
      if (bus_a.BUSY_OUT !== 1'b1) begin
         fails++; $display("FAIL reset_busy_after_load: got %0b, expected 1", bus_a.BUSY_OUT);
      end
      for (int i = 1; i <= 41; i++) begin
         if (i > 1) step();
         d = (k / 4) % 4;
         tests++;
         if (bus_a.SEG_SELECT_OUT !== 2'(d)) begin
            fails++; $display("FAIL reset_seg k=%0d: got %0d, expected %0d", k, bus_a.SEG_SELECT_OUT, d);
         end
         tests++;
         if (bus_a.BIN_OUT !== ((k < 16) ? 4'h0 : nib(v, d))) begin
            fails++; $display("FAIL reset_bin k=%0d: got %0h, expected %0h", k, bus_a.BIN_OUT,
                              (k < 16) ? 4'h0 : nib(v, d));
         end
         tests++;
         if (bus_a.FRAME_OUT !== (k == 16)) begin
            fails++; $display("FAIL reset_frame k=%0d: got %0b, expected %0b", k, bus_a.FRAME_OUT, k == 16);
         end
      end
      rst_n = 1'b0;
      #1;
      outs = {bus_a.SEG_SELECT_OUT, bus_a.BIN_OUT, bus_a.DOT_OUT, bus_a.BLANK_OUT,
              bus_a.BUSY_OUT, bus_a.FRAME_OUT};
      tests++;
      if (outs !== 10'h0) begin
         fails++; $display("FAIL reset_midscan: got %0h, expected 0", outs);
      end
      @(negedge clk);
   endtask

   task automatic test_deferred();
      logic [15:0] v;
      v = 16'h1234;
      do_reset();
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = v;
      step();
      bus_a.LOAD_IN = 1'b0;
      run_to(20);
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = 16'hABCD;
      step();
      bus_a.LOAD_IN = 1'b0;
      tests++;
      if (bus_a.BUSY_OUT !== 1'b1 || bus_a.SEG_SELECT_OUT !== 2'd1) begin
         fails++; $display("FAIL deferred_busy: got busy=%0b seg=%0d, expected busy=1 seg=1",
                           bus_a.BUSY_OUT, bus_a.SEG_SELECT_OUT);
      end
      while (k < 31) begin
         step();
         tests++;
         if (bus_a.BIN_OUT !== nib(v, (k / 4) % 4) || bus_a.BUSY_OUT !== 1'b1) begin
            fails++; $display("FAIL deferred_old_value k=%0d: got bin=%0h busy=%0b, expected bin=%0h busy=1",
                              k, bus_a.BIN_OUT, bus_a.BUSY_OUT, nib(v, (k / 4) % 4));
         end
      end
      step();
      tests++;
      if ({bus_a.FRAME_OUT, bus_a.BUSY_OUT, bus_a.SEG_SELECT_OUT, bus_a.BIN_OUT} !== {1'b1, 1'b0, 2'd0, 4'hD}) begin
         fails++; $display("FAIL deferred_apply: got frame=%0b busy=%0b seg=%0d bin=%0h, expected 1 0 0 d",
                           bus_a.FRAME_OUT, bus_a.BUSY_OUT, bus_a.SEG_SELECT_OUT, bus_a.BIN_OUT);
      end
      step();
      tests++;
      if (bus_a.FRAME_OUT !== 1'b0) begin
         fails++; $display("FAIL deferred_frame_width: got %0b, expected 0", bus_a.FRAME_OUT);
      end
   endtask

   // Continues from test_deferred: shadow is 0xABCD, next boundary at k=48.
   task automatic test_overwrite();
      run_to(36);
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = 16'h1111;
      step();
      bus_a.LOAD_IN = 1'b0;
      run_to(40);
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = 16'h2222;
      step();
      bus_a.LOAD_IN = 1'b0;
      tests++;
      if (bus_a.BUSY_OUT !== 1'b1) begin
         fails++; $display("FAIL overwrite_busy: got %0b, expected 1", bus_a.BUSY_OUT);
      end
      run_to(48);
      tests++;
      if (bus_a.FRAME_OUT !== 1'b1 || bus_a.BUSY_OUT !== 1'b0) begin
         fails++; $display("FAIL overwrite_frame: got frame=%0b busy=%0b, expected 1 0",
                           bus_a.FRAME_OUT, bus_a.BUSY_OUT);
      end
      repeat (16) begin
         tests++;
         if (bus_a.BIN_OUT !== 4'h2) begin
            fails++; $display("FAIL overwrite_last_wins k=%0d: got %0h, expected 2", k, bus_a.BIN_OUT);
         end
         if (k == 63) begin
            tests++;
            if (bus_a.BUSY_OUT !== 1'b1) begin
               fails++; $display("FAIL overwrite_pending_3333: got %0b, expected 1", bus_a.BUSY_OUT);
            end
         end
         bus_a.LOAD_IN  = (k == 52) || (k == 63);
         bus_a.VALUE_IN = (k == 52) ? 16'h3333 : 16'h5678;
         step();
         bus_a.LOAD_IN = 1'b0;
      end
      tests++;
      if ({bus_a.FRAME_OUT, bus_a.BUSY_OUT, bus_a.SEG_SELECT_OUT, bus_a.BIN_OUT} !== {1'b1, 1'b0, 2'd0, 4'h8}) begin
         fails++; $display("FAIL boundary_load: got frame=%0b busy=%0b seg=%0d bin=%0h, expected 1 0 0 8",
                           bus_a.FRAME_OUT, bus_a.BUSY_OUT, bus_a.SEG_SELECT_OUT, bus_a.BIN_OUT);
      end
      run_to(80);
      tests++;
      if ({bus_a.FRAME_OUT, bus_a.BUSY_OUT, bus_a.BIN_OUT} !== {1'b0, 1'b0, 4'h8}) begin
         fails++; $display("FAIL boundary_discard: got frame=%0b busy=%0b bin=%0h, expected 0 0 8",
                           bus_a.FRAME_OUT, bus_a.BUSY_OUT, bus_a.BIN_OUT);
      end
   endtask

   task automatic test_blanking();
      logic [15:0] vals [3];
      logic [3:0]  dots [3];
      logic [3:0]  exp_blank [3];
      int          d;
      vals = '{16'h0050, 16'h0000, 16'h0005};
      dots = '{4'b0000, 4'b0000, 4'b0100};
      exp_blank = '{4'b1100, 4'b1110, 4'b1010};
      do_reset();
      bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = vals[0]; bus_a.DOTS_IN = dots[0];
      step();
      bus_a.LOAD_IN = 1'b0;
      run_to(16);
      for (int p = 0; p < 3; p++) begin
         for (int j = 0; j < 16; j++) begin
            d = j / 4;
            if (j == 0 && p < 2) begin
               bus_a.LOAD_IN = 1'b1; bus_a.VALUE_IN = vals[p+1]; bus_a.DOTS_IN = dots[p+1];
            end
            tests++;
            if ({bus_a.BLANK_OUT, bus_a.DOT_OUT, bus_a.BIN_OUT} !== {exp_blank[p][d], dots[p][d], nib(vals[p], d)}) begin
               fails++; $display("FAIL blank_p%0d_d%0d: got blank=%0b dot=%0b bin=%0h, expected %0b %0b %0h",
                                 p, d, bus_a.BLANK_OUT, bus_a.DOT_OUT, bus_a.BIN_OUT,
                                 exp_blank[p][d], dots[p][d], nib(vals[p], d));
            end
            step();
            bus_a.LOAD_IN = 1'b0;
         end
      end
   endtask

   task automatic test_no_lzb();
      logic [15:0] v;
      v = 16'h0300;
      do_reset();
      bus_b.LOAD_IN = 1'b1; bus_b.VALUE_IN = 16'h0000;
      step();
      bus_b.LOAD_IN = 1'b0;
      while (k < 48) begin
         if (k == 16) begin
            bus_b.LOAD_IN = 1'b1; bus_b.VALUE_IN = v;
         end
         step();
         bus_b.LOAD_IN = 1'b0;
         tests++;
         if (bus_b.BLANK_OUT !== 1'b0 || bus_b.BIN_OUT !== ((k < 32) ? 4'h0 : nib(v, (k / 4) % 4))) begin
            fails++; $display("FAIL no_lzb k=%0d: got blank=%0b bin=%0h, expected 0 %0h", k,
                              bus_b.BLANK_OUT, bus_b.BIN_OUT, (k < 32) ? 4'h0 : nib(v, (k / 4) % 4));
         end
      end
   endtask

   task automatic test_stress();
      int          m_cnt, m_dig, gap;
      logic [15:0] m_shadow, m_pval, val;
      logic [3:0]  m_sdots, m_pdots, dts;
      logic        m_pend, m_frame, ld, tick, bnd, exp_blank;
      m_cnt = 0; m_dig = 0; m_shadow = 16'h0; m_sdots = 4'h0;
      m_pend = 1'b0; m_pval = 16'h0; m_pdots = 4'h0; m_frame = 1'b0;
      gap = $urandom_range(0, 9);
      do_reset();
      repeat (10000) begin
         ld = (gap == 0);
         val = 16'($urandom);
         // Bias toward zero upper nibbles so blanking paths get exercised.
         if ($urandom_range(0, 2) == 0) val = val & 16'h00FF;
         dts = 4'($urandom);
         if (ld) gap = $urandom_range(0, 9);
         else gap--;
         bus_c.LOAD_IN = ld; bus_c.VALUE_IN = val; bus_c.DOTS_IN = dts;
         step();
         bus_c.LOAD_IN = 1'b0;
         tick = (m_cnt == 1);
         bnd = tick && (m_dig == 3);
         m_frame = 1'b0;
         if (bnd && ld) begin
            m_shadow = val; m_sdots = dts; m_pend = 1'b0; m_frame = 1'b1;
         end else if (bnd && m_pend) begin
            m_shadow = m_pval; m_sdots = m_pdots; m_pend = 1'b0; m_frame = 1'b1;
         end else if (!bnd && ld) begin
            m_pend = 1'b1; m_pval = val; m_pdots = dts;
         end
         m_cnt = tick ? 0 : m_cnt + 1;
         if (tick) m_dig = (m_dig + 1) % 4;
         exp_blank = (m_dig != 0) && ((m_shadow >> (4 * m_dig)) == 16'h0) && !m_sdots[m_dig];
         tests++;
         if ({bus_c.SEG_SELECT_OUT, bus_c.BIN_OUT, bus_c.DOT_OUT, bus_c.BLANK_OUT} !==
             {2'(m_dig), nib(m_shadow, m_dig), m_sdots[m_dig], exp_blank}) begin
            fails++; $display("FAIL stress_digit k=%0d: got seg=%0d bin=%0h dot=%0b blank=%0b, expected %0d %0h %0b %0b",
                              k, bus_c.SEG_SELECT_OUT, bus_c.BIN_OUT, bus_c.DOT_OUT, bus_c.BLANK_OUT,
                              m_dig, nib(m_shadow, m_dig), m_sdots[m_dig], exp_blank);
         end
         tests++;
         if (bus_c.BUSY_OUT !== m_pend || bus_c.FRAME_OUT !== m_frame) begin
            fails++; $display("FAIL stress_handshake k=%0d: got busy=%0b frame=%0b, expected %0b %0b",
                              k, bus_c.BUSY_OUT, bus_c.FRAME_OUT, m_pend, m_frame);
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_deferred();
      test_overwrite();
      test_blanking();
      test_no_lzb();
      test_stress();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
